perceptron_update_sched: RTL

- Controller for the perceptron weight tables: HOB table, complement-HOB table and LOB table, each with one read port and one write port.
- Clears all entries after reset, buffers execute-stage training requests in a small FIFO, and runs one read-modify-write per request.
- Arbitrates the shared table read port: fetch lookup has priority; a pending update steals the port only when the FIFO is full.
- Sits between the execute-stage update interface and the weight RAMs of the branch predictor.

---
 rtl/perceptron_update_sched_if.sv | 28 ++
 rtl/perceptron_update_sched.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/perceptron_update_sched_if.sv
// Execute-stage training request channel into the perceptron update scheduler.
// The master presents {idx, dir, ghr}; a request transfers when upd_valid & upd_ready.
interface perceptron_update_sched_if #(
   parameter int IDX_W    = 6,
   parameter int GHR_SIZE = 8
);
   logic                upd_valid;
   logic                upd_ready;
   logic [IDX_W-1:0]    upd_idx;
   logic                upd_dir;
   logic [GHR_SIZE-1:0] upd_ghr;

   modport master (
      output upd_valid,
      output upd_idx,
      output upd_dir,
      output upd_ghr,
      input  upd_ready
   );

   modport slave (
      input  upd_valid,
      input  upd_idx,
      input  upd_dir,
      input  upd_ghr,
      output upd_ready
   );
endinterface

// File: rtl/perceptron_update_sched.sv
// Perceptron weight-table update scheduler: clears the HOB / complement-HOB / LOB
// tables after reset, queues training requests and performs one read-modify-write
// per request, sharing the table read port with fetch lookups.
module perceptron_update_sched #(
   parameter int ENTRIES    = 64,
   parameter int IDX_W      = 6,
   parameter int GHR_SIZE   = 8,
   parameter int HOB        = 3,
   parameter int LOB        = 5,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    fetch_rd_req,
   input  logic [IDX_W-1:0]        fetch_rd_idx,
   output logic                    fetch_rd_stall,
   output logic [IDX_W-1:0]        rd_addr,
   input  logic [HOB*GHR_SIZE-1:0] rd_hob,
   input  logic [LOB*GHR_SIZE-1:0] rd_lob,
   perceptron_update_sched_if.slave upd,
   input  logic                    stall,
   output logic                    wr_en,
   output logic [IDX_W-1:0]        wr_addr,
   output logic [HOB*GHR_SIZE-1:0] wr_hob,
   output logic [HOB*GHR_SIZE-1:0] wr_hob_c,
   output logic [LOB*GHR_SIZE-1:0] wr_lob,
   output logic                    init_busy,
   output logic                    busy
);

   localparam int WW = HOB + LOB;
   localparam int EW = IDX_W + 1 + GHR_SIZE;
   localparam int PW = $clog2(FIFO_DEPTH);

   localparam logic [2:0] S_INIT = 3'd0;
   localparam logic [2:0] S_IDLE = 3'd1;
   localparam logic [2:0] S_RD   = 3'd2;
   localparam logic [2:0] S_CALC = 3'd3;
   localparam logic [2:0] S_WR   = 3'd4;

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ENTRIES - 1);
   localparam logic [PW:0]      FULL_CNT  = (PW+1)'(FIFO_DEPTH);
   localparam logic [PW:0]      ONE_C     = (PW+1)'(1);
   localparam logic [PW-1:0]    ONE_P     = PW'(1);
   localparam logic [IDX_W-1:0] ONE_I     = IDX_W'(1);
   localparam logic [WW:0]      ONE_X     = (WW+1)'(1);
   localparam logic [WW-1:0]    ONE_W     = WW'(1);
   localparam logic [WW-1:0]    W_MIN     = {1'b1, {(WW-1){1'b0}}};
   localparam logic [WW-1:0]    W_MAX     = {1'b0, {(WW-1){1'b1}}};

   logic [2:0]       state_q, state_d;
   logic [IDX_W-1:0] sweep_q;

   logic [EW-1:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [PW:0]      cnt_q, cnt_d;
   logic             full, empty, push, pop;

   logic [EW-1:0]       head;
   logic [IDX_W-1:0]    head_idx;
   logic                head_dir;
   logic [GHR_SIZE-1:0] head_ghr;
   logic                upd_grant;

   logic [HOB*GHR_SIZE-1:0] new_hob, new_hob_c;
   logic [LOB*GHR_SIZE-1:0] new_lob;
   logic [WW-1:0]           w_cur, w_new, w_neg;
   logic [WW:0]             w_sum;

   assign full  = (cnt_q == FULL_CNT);
   assign empty = (cnt_q == '0);
   assign init_busy     = (state_q == S_INIT);
   assign upd.upd_ready = ~init_busy & ~full;
   assign push  = upd.upd_valid & upd.upd_ready;
   assign pop   = (state_q == S_WR);

   assign head     = fifo_mem[rd_ptr_q];
   assign head_idx = head[EW-1 -: IDX_W];
   assign head_dir = head[GHR_SIZE];
   assign head_ghr = head[GHR_SIZE-1:0];

   // Fetch owns the read port unless the queue is full while an update waits in RD.
   assign upd_grant      = (state_q == S_RD) & ~(fetch_rd_req & ~full);
   assign rd_addr        = upd_grant ? head_idx : fetch_rd_idx;
   assign fetch_rd_stall = upd_grant & fetch_rd_req;
   assign busy           = ~empty | (state_q == S_RD) | (state_q == S_CALC) | (state_q == S_WR);

   // Queue occupancy after this cycle's push/pop.
   always_comb begin
      cnt_d = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + ONE_C;
         2'b01:   cnt_d = cnt_q - ONE_C;
         default: cnt_d = cnt_q;
      endcase
   end

   // Next-state selection; stall only gates entry into RD.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT: if (sweep_q == LAST_IDX) state_d = S_IDLE;
         S_IDLE: if (!empty && !stall) state_d = S_RD;
         S_RD:   if (upd_grant) state_d = S_CALC;
         S_CALC: state_d = S_WR;
         S_WR:   state_d = (cnt_d != '0 && !stall) ? S_RD : S_IDLE;
         default: state_d = S_INIT;
      endcase
   end

   // Per-weight saturating +/-1 step and saturating negation for the complement table.
   always_comb begin
      new_hob   = '0;
      new_lob   = '0;
      new_hob_c = '0;
      w_cur     = '0;
      w_sum     = '0;
      w_new     = '0;
      w_neg     = '0;
      for (int unsigned i = 0; i < GHR_SIZE; i++) begin
         w_cur = {rd_hob[i*HOB +: HOB], rd_lob[i*LOB +: LOB]};
         if (head_dir == head_ghr[i]) w_sum = {w_cur[WW-1], w_cur} + ONE_X;
         else                         w_sum = {w_cur[WW-1], w_cur} - ONE_X;
         if (w_sum[WW] != w_sum[WW-1]) w_new = {w_sum[WW], {(WW-1){~w_sum[WW]}}};
         else                          w_new = w_sum[WW-1:0];
         if (w_new == W_MIN) w_neg = W_MAX;
         else                w_neg = ~w_new + ONE_W;
         new_hob[i*HOB +: HOB]   = w_new[WW-1 -: HOB];
         new_lob[i*LOB +: LOB]   = w_new[LOB-1:0];
         new_hob_c[i*HOB +: HOB] = w_neg[WW-1 -: HOB];
      end
   end

   // FSM, clear sweep and registered table write port.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_INIT;
         sweep_q  <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_hob   <= '0;
         wr_hob_c <= '0;
         wr_lob   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_INIT: begin
               wr_en    <= 1'b1;
               wr_addr  <= sweep_q;
               wr_hob   <= '0;
               wr_hob_c <= '0;
               wr_lob   <= '0;
               sweep_q  <= (sweep_q == LAST_IDX) ? '0 : sweep_q + ONE_I;
            end
            S_CALC: begin
               wr_en    <= 1'b1;
               wr_addr  <= head_idx;
               wr_hob   <= new_hob;
               wr_hob_c <= new_hob_c;
               wr_lob   <= new_lob;
            end
            default: wr_en <= 1'b0;
         endcase
      end
   end

   // Request queue pointers and occupancy; contents are dropped on reset by clearing these.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + ONE_P;
         if (pop)  rd_ptr_q <= rd_ptr_q + ONE_P;
         cnt_q <= cnt_d;
      end
   end

   // Request storage: {idx, dir, ghr}.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= {upd.upd_idx, upd.upd_dir, upd.upd_ghr};
   end

endmodule
